// File: rtl/lamp_safety_driver_if.sv
// Lamp-code link between traffic_controller and lamp_safety_driver: the incoming
// code and fault clear, plus the physical lamp drives and fault status going back.
interface lamp_safety_driver_if;
    logic [3:0] code_in;
    logic       clr_fault;
    logic       lamp_red;
    logic       lamp_amb;
    logic       lamp_grn;
    logic       fault;
    logic [1:0] fault_code;

    modport master (
        output code_in,
        output clr_fault,
        input  lamp_red,
        input  lamp_amb,
        input  lamp_grn,
        input  fault,
        input  fault_code
    );

    modport slave (
        input  code_in,
        input  clr_fault,
        output lamp_red,
        output lamp_amb,
        output lamp_grn,
        output fault,
        output fault_code
    );
endinterface

// File: rtl/lamp_safety_driver.sv
// Drives red/amber/green lamps from a controller lamp code, enforcing code legality,
// phase order and minimum dwell; any violation latches a flashing-amber fault state.
module lamp_safety_driver #(
    parameter int MIN_RED    = 8,
    parameter int MIN_AMB    = 2,
    parameter int MIN_GRN    = 6,
    parameter int BLINK_HALF = 4,
    parameter int CNT_W      = 8
) (
    input logic                 clk,
    input logic                 res_n,
    lamp_safety_driver_if.slave bus
);

    localparam logic [3:0] CODE_RED      = 4'b1000;
    localparam logic [3:0] CODE_AMB      = 4'b0100;
    localparam logic [3:0] CODE_GRN      = 4'b0010;
    localparam logic [3:0] CODE_DISABLED = 4'b1111;
    localparam logic [3:0] CODE_CTRL_RST = 4'b1010;

    localparam int BLINK_W = (2 * BLINK_HALF > 1) ? $clog2(2 * BLINK_HALF) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(2 * BLINK_HALF - 1);
    localparam logic [BLINK_W-1:0] BLINK_ON   = BLINK_W'(BLINK_HALF);

    localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DWELL_MAX = '1;

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_STANDBY, ST_FAULT} state_t;
    typedef enum logic [1:0] {PH_RED, PH_AMB, PH_GRN} phase_t;
    typedef enum logic [1:0] {FC_NONE, FC_ILLEGAL, FC_SEQUENCE, FC_DWELL} fault_code_t;

    state_t              state;
    phase_t              cur;
    logic [CNT_W-1:0]    dwell;
    logic [BLINK_W-1:0]  blink_cnt;
    fault_code_t         fault_code_q;

    // Decoded view of the incoming code relative to the current phase.
    logic                is_phase;
    phase_t              code_ph;
    phase_t              succ_ph;
    logic [CNT_W-1:0]    min_dwell;

    // Next-state decision.
    state_t              state_d;
    fault_code_t         cause_d;
    logic                load_red;
    logic                advance;
    logic                hold;
    phase_t              phase_d;
    logic                blinking_d;
    logic                blink_restart;
    logic [BLINK_W-1:0]  blink_next;
    logic                amb_blink;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        is_phase = 1'b1;
        code_ph  = PH_RED;
        case (bus.code_in)
            CODE_RED: code_ph = PH_RED;
            CODE_AMB: code_ph = PH_AMB;
            CODE_GRN: code_ph = PH_GRN;
            default:  is_phase = 1'b0;
        endcase

        succ_ph   = PH_RED;
        min_dwell = CNT_W'(MIN_AMB);
        case (cur)
            PH_RED: begin
                succ_ph   = PH_GRN;
                min_dwell = CNT_W'(MIN_RED);
            end
            PH_GRN: begin
                succ_ph   = PH_AMB;
                min_dwell = CNT_W'(MIN_GRN);
            end
            default: begin
                succ_ph   = PH_RED;
                min_dwell = CNT_W'(MIN_AMB);
            end
        endcase
    end

    always_comb begin
        state_d  = state;
        cause_d  = FC_NONE;
        load_red = 1'b0;
        advance  = 1'b0;
        hold     = 1'b0;

        unique case (state)
            ST_INIT: begin
                case (bus.code_in)
                    CODE_RED: begin
                        state_d  = ST_RUN;
                        load_red = 1'b1;
                    end
                    CODE_DISABLED:                     state_d = ST_STANDBY;
                    CODE_AMB, CODE_GRN, CODE_CTRL_RST: state_d = ST_INIT;
                    default: begin
                        state_d = ST_FAULT;
                        cause_d = FC_ILLEGAL;
                    end
                endcase
            end

            ST_RUN: begin
                // Checks are ordered so an illegal code wins over a bad sequence,
                // which in turn wins over a short dwell.
                if (is_phase) begin
                    if (code_ph == cur) begin
                        hold = 1'b1;
                    end else if (code_ph != succ_ph) begin
                        state_d = ST_FAULT;
                        cause_d = FC_SEQUENCE;
                    end else if (dwell < min_dwell) begin
                        state_d = ST_FAULT;
                        cause_d = FC_DWELL;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (bus.code_in == CODE_DISABLED) begin
                    state_d = ST_STANDBY;
                end else if (bus.code_in == CODE_CTRL_RST) begin
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_FAULT;
                    cause_d = FC_ILLEGAL;
                end
            end

            ST_STANDBY: begin
                case (bus.code_in)
                    CODE_RED: begin
                        state_d  = ST_RUN;
                        load_red = 1'b1;
                    end
                    CODE_CTRL_RST:                     state_d = ST_INIT;
                    CODE_DISABLED, CODE_AMB, CODE_GRN: state_d = ST_STANDBY;
                    default: begin
                        state_d = ST_FAULT;
                        cause_d = FC_ILLEGAL;
                    end
                endcase
            end

            ST_FAULT: begin
                if (bus.clr_fault && bus.code_in == CODE_RED) begin
                    state_d  = ST_RUN;
                    load_red = 1'b1;
                end
            end
        endcase

        phase_d = load_red ? PH_RED : (advance ? code_ph : cur);

        blinking_d    = (state_d == ST_STANDBY) || (state_d == ST_FAULT);
        blink_restart = blinking_d && (state_d != state);
        blink_next    = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
        amb_blink     = blink_restart || (blink_next < BLINK_ON);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples values from before this edge, independent of statement order.
        if (!res_n) begin
            state          <= ST_INIT;
            cur            <= PH_RED;
            dwell          <= '0;
            blink_cnt      <= '0;
            fault_code_q   <= FC_NONE;
            bus.lamp_red   <= 1'b1;
            bus.lamp_amb   <= 1'b0;
            bus.lamp_grn   <= 1'b0;
            bus.fault      <= 1'b0;
            bus.fault_code <= 2'd0;
        end else begin
            state <= state_d;
            cur   <= phase_d;

            if (load_red || advance) begin
                dwell <= DWELL_ONE;
            end else if (hold && dwell != DWELL_MAX) begin
                dwell <= dwell + 1'b1;
            end

            if (!blinking_d || blink_restart) begin
                blink_cnt <= '0;
            end else begin
                blink_cnt <= blink_next;
            end

            unique case (state_d)
                ST_INIT: begin
                    bus.lamp_red   <= 1'b1;
                    bus.lamp_amb   <= 1'b0;
                    bus.lamp_grn   <= 1'b0;
                    bus.fault      <= 1'b0;
                    bus.fault_code <= 2'd0;
                    fault_code_q   <= FC_NONE;
                end
                ST_RUN: begin
                    bus.lamp_red   <= (phase_d == PH_RED);
                    bus.lamp_amb   <= (phase_d == PH_AMB);
                    bus.lamp_grn   <= (phase_d == PH_GRN);
                    bus.fault      <= 1'b0;
                    bus.fault_code <= 2'd0;
                    fault_code_q   <= FC_NONE;
                end
                ST_STANDBY: begin
                    bus.lamp_red   <= 1'b0;
                    bus.lamp_amb   <= amb_blink;
                    bus.lamp_grn   <= 1'b0;
                    bus.fault      <= 1'b0;
                    bus.fault_code <= 2'd0;
                    fault_code_q   <= FC_NONE;
                end
                ST_FAULT: begin
                    bus.lamp_red <= 1'b0;
                    bus.lamp_amb <= amb_blink;
                    bus.lamp_grn <= 1'b0;
                    bus.fault    <= 1'b1;
                    // Only the first cause is recorded; later violations leave it alone.
                    if (state != ST_FAULT) begin
                        fault_code_q   <= cause_d;
                        bus.fault_code <= 2'(cause_d);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lamp_safety_driver.sv
// Directed bench for lamp_safety_driver: phase cycling, each fault cause, fault
// clearing, standby blink, reset during fault and dwell saturation.
module tb_lamp_safety_driver;

    logic clk = 1'b0;
    logic res_n;

    lamp_safety_driver_if bus ();

    lamp_safety_driver #(
        .MIN_RED   (8),
        .MIN_AMB   (2),
        .MIN_GRN   (6),
        .BLINK_HALF(4),
        .CNT_W     (8)
    ) dut (
        .clk  (clk),
        .res_n(res_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Output word: {red, amber, green, fault, fault_code[1:0]}
    localparam logic [5:0] O_RED = 6'b100_0_00;
    localparam logic [5:0] O_AMB = 6'b010_0_00;
    localparam logic [5:0] O_GRN = 6'b001_0_00;
    localparam logic [5:0] O_DARK = 6'b000_0_00;

    function automatic logic [5:0] outs();
        return {bus.lamp_red, bus.lamp_amb, bus.lamp_grn, bus.fault, bus.fault_code};
    endfunction

    function automatic logic [5:0] fault_word(input logic amb, input logic [1:0] fc);
        return {1'b0, amb, 1'b0, 1'b1, fc};
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [3:0] code, input logic clr);
        bus.code_in   = code;
        bus.clr_fault = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input logic [3:0] code, input logic clr, input logic [5:0] exp,
                            input string tag);
        step(code, clr);
        check(tag, outs(), exp);
    endtask

    initial begin
        bus.code_in   = 4'b0011;
        bus.clr_fault = 1'b1;
        res_n         = 1'b0;

        // Reset wins even with an illegal code and clr_fault present.
        step_chk(4'b0011, 1'b1, O_RED, "reset");
        res_n = 1'b1;

        // T1: full legal cycle at exact minimum dwells, one cycle of latency.
        for (int i = 0; i < 8; i++) step_chk(4'b1000, 1'b0, O_RED, $sformatf("t1_red%0d", i));
        for (int i = 0; i < 6; i++) step_chk(4'b0010, 1'b0, O_GRN, $sformatf("t1_grn%0d", i));
        for (int i = 0; i < 2; i++) step_chk(4'b0100, 1'b0, O_AMB, $sformatf("t1_amb%0d", i));
        step_chk(4'b1000, 1'b0, O_RED, "t1_red_again");

        // T2: red held 7 cycles total, then green is one cycle too early.
        for (int i = 0; i < 6; i++) step(4'b1000, 1'b0);
        step_chk(4'b0010, 1'b0, fault_word(1'b1, 2'd3), "t2_dwell_short");
        // Amber: on for cycles 0..3 after entry, off for 4..7, on again at 8.
        for (int i = 1; i <= 8; i++)
            step_chk(4'b0010, 1'b0, fault_word((i % 8) < 4, 2'd3), $sformatf("t2_blink%0d", i));

        // T4: clear needs red on the same edge.
        step_chk(4'b0010, 1'b1, fault_word(1'b1, 2'd3), "t4_clr_wrong_code");
        step_chk(4'b1000, 1'b1, O_RED, "t4_clr_ok");

        // T3: red straight to amber is a sequence fault; later illegal code keeps cause.
        step_chk(4'b0100, 1'b0, fault_word(1'b1, 2'd2), "t3_bad_seq");
        step_chk(4'b0011, 1'b0, fault_word(1'b1, 2'd2), "t3_cause_held");

        // T6a: one reset edge during FAULT.
        res_n = 1'b0;
        step_chk(4'b0011, 1'b0, O_RED, "t6_reset_in_fault");
        res_n = 1'b1;

        // T5: green -> standby blink -> controller reset -> INIT ignores green.
        for (int i = 0; i < 8; i++) step(4'b1000, 1'b0);
        step_chk(4'b0010, 1'b0, O_GRN, "t5_grn");
        step_chk(4'b1111, 1'b0, O_AMB, "t5_standby_entry");
        for (int i = 1; i <= 4; i++)
            step_chk(4'b1111, 1'b0, (i < 4) ? O_AMB : O_DARK, $sformatf("t5_blink%0d", i));
        step_chk(4'b1010, 1'b0, O_RED, "t5_ctrl_reset");
        step_chk(4'b0010, 1'b0, O_RED, "t5_init_hold");

        // Illegal code in INIT, then illegal code in RUN.
        step_chk(4'b0001, 1'b0, fault_word(1'b1, 2'd1), "init_illegal");
        step_chk(4'b1000, 1'b1, O_RED, "clr_from_illegal");
        step_chk(4'b0110, 1'b0, fault_word(1'b1, 2'd1), "run_illegal");
        step_chk(4'b1000, 1'b1, O_RED, "clr_again");

        // T6b: hold red past 256 edges; a wrapping counter would read small and fault.
        for (int i = 0; i < 258; i++) step(4'b1000, 1'b0);
        check("t6_long_red", outs(), O_RED);
        step_chk(4'b0010, 1'b0, O_GRN, "t6_grn_after_saturation");

        // Green one cycle short of its minimum: dwell fault.
        for (int i = 0; i < 4; i++) step(4'b0010, 1'b0);
        step_chk(4'b0100, 1'b0, fault_word(1'b1, 2'd3), "grn_dwell_short");
        step_chk(4'b1000, 1'b1, O_RED, "final_clr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
